// File: rtl/nf10_proc_common_pkg.sv
// Shared definitions for the NetFPGA-10G processor-side register blocks:
// handshake FSM encoding and the address-decode width helpers.
package nf10_proc_common_pkg;

    // Bus handshake states: accept an access, acknowledge it, wait for CS to drop.
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ACK  = 2'd1,
        ST_HOLD = 2'd2
    } ipif_state_e;

    // Ceiling log2; log2ceil(1) is 0.
    function automatic int log2ceil(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

    // Number of byte-offset address bits below the register index.
    function automatic int addrLsb(input int dataWidth);
        return log2ceil(dataWidth / 8);
    endfunction

    // Register index width, never narrower than one bit.
    function automatic int idxWidth(input int totalRegs);
        return (totalRegs <= 2) ? 1 : log2ceil(totalRegs);
    endfunction

    // Keeps vectors and arrays legal when a register group is empty.
    function automatic int atLeastOne(input int n);
        return (n > 0) ? n : 1;
    endfunction

endpackage

// File: rtl/ipif_be_merge.sv
// Byte-lane merge: each lane takes the new data when its byte enable is set,
// otherwise keeps the old register contents.
module ipif_be_merge #(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]   oldVal_i,
    input  logic [DATA_WIDTH-1:0]   newData_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    output logic [DATA_WIDTH-1:0]   merged_o
);

    // Select old or new byte per lane.
    always_comb begin
        merged_o = oldVal_i;
        for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            if (be_i[b]) begin
                merged_o[8*b +: 8] = newData_i[8*b +: 8];
            end
        end
    end

endmodule

// File: rtl/ipif_regs_bank.sv
// Software register bank behind the IPIF: WO, RW and RO registers laid out
// contiguously from the base address, one acknowledge per bus access.
module ipif_regs_bank
    import nf10_proc_common_pkg::*;
#(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 32,
    parameter int NUM_WO_REGS        = 1,
    parameter int NUM_RW_REGS        = 8,
    parameter int NUM_RO_REGS        = 17,
    parameter logic [atLeastOne(NUM_WO_REGS+NUM_RW_REGS)*C_S_AXI_DATA_WIDTH-1:0] RESET_VALS = '0,
    parameter logic [atLeastOne(NUM_RO_REGS)-1:0] COR_MASK = '0,
    parameter bit ERR_EN = 1'b1
) (
    input  logic                                                  Bus2IP_Clk,
    input  logic                                                  Bus2IP_Reset,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]                         Bus2IP_Addr,
    input  logic                                                  Bus2IP_CS,
    input  logic                                                  Bus2IP_RNW,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]                         Bus2IP_Data,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]                       Bus2IP_BE,
    output logic [C_S_AXI_DATA_WIDTH-1:0]                         IP2Bus_Data,
    output logic                                                  IP2Bus_RdAck,
    output logic                                                  IP2Bus_WrAck,
    output logic                                                  IP2Bus_Error,
    output logic [atLeastOne(NUM_WO_REGS)*C_S_AXI_DATA_WIDTH-1:0] wo_regs,
    output logic [atLeastOne(NUM_RW_REGS)*C_S_AXI_DATA_WIDTH-1:0] rw_regs,
    input  logic [atLeastOne(NUM_RO_REGS)*C_S_AXI_DATA_WIDTH-1:0] ro_regs,
    output logic [atLeastOne(NUM_WO_REGS+NUM_RW_REGS)-1:0]        wr_strobe,
    output logic [atLeastOne(NUM_RO_REGS)-1:0]                    rd_clear
);

    localparam int DW        = C_S_AXI_DATA_WIDTH;
    localparam int NUM_WR    = NUM_WO_REGS + NUM_RW_REGS;
    localparam int NUM_TOTAL = NUM_WR + NUM_RO_REGS;
    localparam int WR_ALLOC  = atLeastOne(NUM_WR);
    localparam int RO_ALLOC  = atLeastOne(NUM_RO_REGS);
    localparam int ADDR_LSB  = addrLsb(DW);
    localparam int IDX_W     = idxWidth(NUM_TOTAL);

    ipif_state_e           state_q;
    logic [DW-1:0]         regs_q [WR_ALLOC];

    logic                  accRnw_q;
    logic                  accErr_q;
    logic [DW-1:0]         accData_q;
    logic [WR_ALLOC-1:0]   accStrb_q;
    logic [RO_ALLOC-1:0]   accClr_q;

    logic                  rdAck_q;
    logic                  wrAck_q;
    logic                  err_q;
    logic [DW-1:0]         rdData_q;
    logic [WR_ALLOC-1:0]   wrStrobe_q;
    logic [RO_ALLOC-1:0]   rdClear_q;

    logic [IDX_W-1:0]      idx;
    logic [31:0]           idxInt;
    logic                  unmapped;
    logic [WR_ALLOC-1:0]   selWrHit;
    logic [RO_ALLOC-1:0]   selCorHit;
    logic [DW-1:0]         selOld;
    logic [DW-1:0]         readVal;
    logic [DW-1:0]         mergedVal;
    logic                  unusedAddrBits;

    assign idx            = Bus2IP_Addr[ADDR_LSB +: IDX_W];
    assign idxInt         = {{(32-IDX_W){1'b0}}, idx};
    assign unusedAddrBits = ^Bus2IP_Addr;

    // Decode the index into the selected writable register, read value and clear-on-read hit.
    always_comb begin
        selWrHit  = '0;
        selCorHit = '0;
        selOld    = '0;
        readVal   = '0;
        unmapped  = (idxInt >= 32'(NUM_TOTAL));
        for (int r = 0; r < NUM_WR; r++) begin
            if (idxInt == 32'(r)) begin
                selWrHit[r] = 1'b1;
                selOld      = regs_q[r];
                if (r >= NUM_WO_REGS) begin
                    readVal = regs_q[r];
                end
            end
        end
        for (int r = 0; r < NUM_RO_REGS; r++) begin
            if (idxInt == 32'(NUM_WR + r)) begin
                readVal      = ro_regs[r*DW +: DW];
                selCorHit[r] = COR_MASK[r];
            end
        end
    end

    ipif_be_merge #(
        .DATA_WIDTH (DW)
    ) u_be_merge (
        .oldVal_i  (selOld),
        .newData_i (Bus2IP_Data),
        .be_i      (Bus2IP_BE),
        .merged_o  (mergedVal)
    );

    // Handshake FSM: latch and perform the access in IDLE, drive one registered ack in ACK, wait for CS low in HOLD.
    always_ff @(posedge Bus2IP_Clk) begin
        if (Bus2IP_Reset) begin
            state_q    <= ST_IDLE;
            accRnw_q   <= 1'b0;
            accErr_q   <= 1'b0;
            accData_q  <= '0;
            accStrb_q  <= '0;
            accClr_q   <= '0;
            rdAck_q    <= 1'b0;
            wrAck_q    <= 1'b0;
            err_q      <= 1'b0;
            rdData_q   <= '0;
            wrStrobe_q <= '0;
            rdClear_q  <= '0;
            for (int r = 0; r < WR_ALLOC; r++) begin
                regs_q[r] <= RESET_VALS[r*DW +: DW];
            end
        end else begin
            rdAck_q    <= 1'b0;
            wrAck_q    <= 1'b0;
            err_q      <= 1'b0;
            rdData_q   <= '0;
            wrStrobe_q <= '0;
            rdClear_q  <= '0;
            case (state_q)
                ST_IDLE: begin
                    if (Bus2IP_CS) begin
                        accRnw_q  <= Bus2IP_RNW;
                        accErr_q  <= unmapped && ERR_EN;
                        accData_q <= Bus2IP_RNW ? readVal : '0;
                        accStrb_q <= Bus2IP_RNW ? '0 : selWrHit;
                        accClr_q  <= Bus2IP_RNW ? selCorHit : '0;
                        for (int r = 0; r < NUM_WR; r++) begin
                            if (!Bus2IP_RNW && selWrHit[r]) begin
                                regs_q[r] <= mergedVal;
                            end
                        end
                        state_q <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    rdAck_q    <= accRnw_q;
                    wrAck_q    <= !accRnw_q;
                    err_q      <= accErr_q;
                    rdData_q   <= accData_q;
                    wrStrobe_q <= accStrb_q;
                    rdClear_q  <= accClr_q;
                    state_q    <= ST_HOLD;
                end
                ST_HOLD: begin
                    if (!Bus2IP_CS) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign IP2Bus_Data  = rdData_q;
    assign IP2Bus_RdAck = rdAck_q;
    assign IP2Bus_WrAck = wrAck_q;
    assign IP2Bus_Error = err_q;
    assign wr_strobe    = wrStrobe_q;
    assign rd_clear     = rdClear_q;

    if (NUM_WO_REGS > 0) begin : g_wo
        for (genvar i = 0; i < NUM_WO_REGS; i++) begin : g_pack
            assign wo_regs[i*DW +: DW] = regs_q[i];
        end
    end else begin : g_wo_none
        assign wo_regs = '0;
    end

    if (NUM_RW_REGS > 0) begin : g_rw
        for (genvar i = 0; i < NUM_RW_REGS; i++) begin : g_pack
            assign rw_regs[i*DW +: DW] = regs_q[NUM_WO_REGS + i];
        end
    end else begin : g_rw_none
        assign rw_regs = '0;
    end

endmodule

// File: tb/tb_ipif_regs_bank.sv
// Testbench for ipif_regs_bank: directed scenarios plus randomized accesses
// checked against an array-based model of the register map.
module tb_ipif_regs_bank;

    localparam int NWO   = 1;
    localparam int NRW   = 8;
    localparam int NRO   = 17;
    localparam int NWR   = NWO + NRW;
    localparam int TOTAL = NWR + NRO;
    localparam logic [16:0] COR = 17'h10001;

    // Reset image: every writable register gets a distinct value, RW[0] is 0xAA.
    function automatic logic [NWR*32-1:0] buildResetImage();
        logic [NWR*32-1:0] img;
        for (int i = 0; i < NWR; i++) begin
            img[i*32 +: 32] = 32'hC0DE_0000 + 32'(i);
        end
        img[63:32] = 32'h0000_00AA;
        return img;
    endfunction

    localparam logic [NWR*32-1:0] RV = buildResetImage();

    logic          clk;
    logic          rst;
    logic [31:0]   addr;
    logic          cs;
    logic          rnw;
    logic [31:0]   wdata;
    logic [3:0]    busBe;
    logic [31:0]   rdata;
    logic          rdAck;
    logic          wrAck;
    logic          err;
    logic [31:0]   woRegs;
    logic [255:0]  rwRegs;
    logic [543:0]  roRegs;
    logic [8:0]    wrStrobe;
    logic [16:0]   rdClear;

    logic [31:0]   roArr [NRO];
    logic [31:0]   mdl [NWR];
    logic [16:0]   corMask;

    int            nCompared;
    int            nMismatch;

    int            obsAcks;
    int            obsAckAt;
    int            obsStray;
    logic          obsRd;
    logic          obsWr;
    logic [31:0]   obsData;
    logic          obsErr;
    logic [8:0]    obsStrb;
    logic [16:0]   obsClr;
    logic [31:0]   obsWo;
    logic [255:0]  obsRw;

    logic [31:0]   expData;
    logic          expErr;
    logic [8:0]    expStrb;
    logic [16:0]   expClr;

    ipif_regs_bank #(
        .C_S_AXI_DATA_WIDTH (32),
        .C_S_AXI_ADDR_WIDTH (32),
        .NUM_WO_REGS        (NWO),
        .NUM_RW_REGS        (NRW),
        .NUM_RO_REGS        (NRO),
        .RESET_VALS         (RV),
        .COR_MASK           (COR),
        .ERR_EN             (1'b1)
    ) dut (
        .Bus2IP_Clk   (clk),
        .Bus2IP_Reset (rst),
        .Bus2IP_Addr  (addr),
        .Bus2IP_CS    (cs),
        .Bus2IP_RNW   (rnw),
        .Bus2IP_Data  (wdata),
        .Bus2IP_BE    (busBe),
        .IP2Bus_Data  (rdata),
        .IP2Bus_RdAck (rdAck),
        .IP2Bus_WrAck (wrAck),
        .IP2Bus_Error (err),
        .wo_regs      (woRegs),
        .rw_regs      (rwRegs),
        .ro_regs      (roRegs),
        .wr_strobe    (wrStrobe),
        .rd_clear     (rdClear)
    );

    // Free-running 10 ns clock.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Present the RO array to the DUT as one packed bus.
    always_comb begin
        roRegs = '0;
        for (int i = 0; i < NRO; i++) begin
            roRegs[i*32 +: 32] = roArr[i];
        end
    end

    function automatic logic [255:0] packRw();
        logic [255:0] v;
        for (int i = 0; i < NRW; i++) begin
            v[i*32 +: 32] = mdl[NWO + i];
        end
        return v;
    endfunction

    task automatic modelReset();
        logic [NWR*32-1:0] img;
        img = RV;
        for (int i = 0; i < NWR; i++) begin
            mdl[i] = img[i*32 +: 32];
        end
    endtask

    // Reference behaviour of one access: expected bus response and register update.
    task automatic modelAccess(input logic isRead, input int idx, input logic [31:0] data, input logic [3:0] be);
        expErr  = (idx >= TOTAL);
        expData = '0;
        expStrb = '0;
        expClr  = '0;
        if (isRead) begin
            if (idx >= NWO && idx < NWR) begin
                expData = mdl[idx];
            end else if (idx >= NWR && idx < TOTAL) begin
                expData = roArr[idx - NWR];
                expClr[idx - NWR] = corMask[idx - NWR];
            end
        end else if (idx < NWR) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) begin
                    mdl[idx][8*b +: 8] = data[8*b +: 8];
                end
            end
            expStrb[idx] = 1'b1;
        end
    endtask

    // Drive one bus access, keep CS high for holdCycles after the ack, and record what the DUT did.
    task automatic applyStimulus(input logic isRead, input int idx, input logic [31:0] data, input logic [3:0] be, input int holdCycles);
        logic [31:0] a;
        a      = $urandom;
        a[6:2] = idx[4:0];
        @(posedge clk); #1;
        cs    = 1'b1;
        rnw   = isRead;
        addr  = a;
        wdata = data;
        busBe = be;
        obsAcks  = 0;
        obsAckAt = -1;
        obsStray = 0;
        for (int c = 0; c < holdCycles + 6; c++) begin
            @(posedge clk); #1;
            if (rdAck || wrAck) begin
                obsAcks++;
                if (obsAcks == 1) begin
                    obsAckAt = c;
                    obsRd    = rdAck;
                    obsWr    = wrAck;
                    obsData  = rdata;
                    obsErr   = err;
                    obsStrb  = wrStrobe;
                    obsClr   = rdClear;
                    obsWo    = woRegs;
                    obsRw    = rwRegs;
                end
            end else if (err || (|wrStrobe) || (|rdClear)) begin
                obsStray++;
            end
            if (c == holdCycles + 1) begin
                cs = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        cs  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        modelReset();
        nCompared++; if (rwRegs !== packRw()) begin nMismatch++; $display("[TB] FAIL reset.rw_regs got %h want %h", rwRegs, packRw()); end
        nCompared++; if (woRegs !== mdl[0]) begin nMismatch++; $display("[TB] FAIL reset.wo_regs got %h want %h", woRegs, mdl[0]); end
        nCompared++; if (rwRegs[31:0] !== 32'h0000_00AA) begin nMismatch++; $display("[TB] FAIL reset.rw0 got %h want 000000aa", rwRegs[31:0]); end
        nCompared++; if ({rdAck, wrAck, err, wrStrobe, rdClear} !== '0) begin nMismatch++; $display("[TB] FAIL reset.pulses got %b want 0", {rdAck, wrAck, err, wrStrobe, rdClear}); end
        nCompared++; if (rdata !== 32'h0) begin nMismatch++; $display("[TB] FAIL reset.data got %h want 0", rdata); end
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic test_be_write();
        modelAccess(1'b0, 1, 32'hFFFF_FFFF, 4'hF);
        applyStimulus(1'b0, 1, 32'hFFFF_FFFF, 4'hF, 0);
        modelAccess(1'b0, 1, 32'h1234_5678, 4'b0011);
        applyStimulus(1'b0, 1, 32'h1234_5678, 4'b0011, 0);
        nCompared++; if (obsRw[31:0] !== 32'hFFFF_5678) begin nMismatch++; $display("[TB] FAIL be_write.rw0 got %h want ffff5678", obsRw[31:0]); end
        nCompared++; if (obsRw !== packRw()) begin nMismatch++; $display("[TB] FAIL be_write.rw_regs got %h want %h", obsRw, packRw()); end
        nCompared++; if (obsAcks !== 1 || obsWr !== 1'b1 || obsRd !== 1'b0) begin nMismatch++; $display("[TB] FAIL be_write.ack got acks=%0d wr=%b rd=%b want 1/1/0", obsAcks, obsWr, obsRd); end
        nCompared++; if (obsAckAt !== 1) begin nMismatch++; $display("[TB] FAIL be_write.latency got %0d want 1", obsAckAt); end
        nCompared++; if (obsStrb !== 9'b0_0000_0010) begin nMismatch++; $display("[TB] FAIL be_write.strobe got %b want 000000010", obsStrb); end
        nCompared++; if (obsStray !== 0) begin nMismatch++; $display("[TB] FAIL be_write.stray got %0d want 0", obsStray); end
        applyStimulus(1'b0, 1, 32'hDEAD_BEEF, 4'b0000, 0);
        nCompared++; if (obsStrb !== 9'b0_0000_0010 || rwRegs[31:0] !== 32'hFFFF_5678) begin nMismatch++; $display("[TB] FAIL be_write.be0 got strobe=%b rw0=%h want 000000010/ffff5678", obsStrb, rwRegs[31:0]); end
    endtask

    task automatic test_hold_read();
        roArr[2] = 32'h0000_CAFE;
        modelAccess(1'b1, NWR + 2, 32'h0, 4'h0);
        applyStimulus(1'b1, NWR + 2, 32'h0, 4'h0, 10);
        nCompared++; if (obsAcks !== 1 || obsRd !== 1'b1) begin nMismatch++; $display("[TB] FAIL hold_read.acks got %0d rd=%b want 1/1", obsAcks, obsRd); end
        nCompared++; if (obsData !== 32'h0000_CAFE) begin nMismatch++; $display("[TB] FAIL hold_read.data got %h want 0000cafe", obsData); end
        nCompared++; if (obsClr !== 17'h0 || obsErr !== 1'b0) begin nMismatch++; $display("[TB] FAIL hold_read.side got clr=%h err=%b want 0/0", obsClr, obsErr); end
    endtask

    task automatic test_cor();
        applyStimulus(1'b1, NWR + 0, 32'h0, 4'h0, 2);
        nCompared++; if (obsClr !== 17'h00001 || obsRd !== 1'b1) begin nMismatch++; $display("[TB] FAIL cor.ro0 got clr=%h rd=%b want 00001/1", obsClr, obsRd); end
        nCompared++; if (obsStray !== 0) begin nMismatch++; $display("[TB] FAIL cor.once got stray=%0d want 0", obsStray); end
        applyStimulus(1'b1, NWR + 1, 32'h0, 4'h0, 0);
        nCompared++; if (obsClr !== 17'h0) begin nMismatch++; $display("[TB] FAIL cor.ro1 got clr=%h want 0", obsClr); end
    endtask

    task automatic test_unmapped();
        applyStimulus(1'b1, 26, 32'h0, 4'h0, 0);
        nCompared++; if (obsRd !== 1'b1 || obsErr !== 1'b1 || obsData !== 32'h0) begin nMismatch++; $display("[TB] FAIL unmapped.read got rd=%b err=%b data=%h want 1/1/0", obsRd, obsErr, obsData); end
        applyStimulus(1'b0, 9, 32'hFFFF_FFFF, 4'hF, 0);
        nCompared++; if (obsWr !== 1'b1 || obsErr !== 1'b0 || obsStrb !== 9'h0) begin nMismatch++; $display("[TB] FAIL unmapped.ro_write got wr=%b err=%b strobe=%b want 1/0/0", obsWr, obsErr, obsStrb); end
        nCompared++; if (rwRegs !== packRw() || woRegs !== mdl[0]) begin nMismatch++; $display("[TB] FAIL unmapped.no_change got rw=%h wo=%h want %h %h", rwRegs, woRegs, packRw(), mdl[0]); end
        applyStimulus(1'b1, 0, 32'h0, 4'h0, 0);
        nCompared++; if (obsData !== 32'h0 || obsErr !== 1'b0 || obsRd !== 1'b1) begin nMismatch++; $display("[TB] FAIL unmapped.wo_read got data=%h err=%b rd=%b want 0/0/1", obsData, obsErr, obsRd); end
        applyStimulus(1'b0, 31, 32'h5555_5555, 4'hF, 1);
        nCompared++; if (obsWr !== 1'b1 || obsErr !== 1'b1 || rwRegs !== packRw()) begin nMismatch++; $display("[TB] FAIL unmapped.write31 got wr=%b err=%b rw=%h", obsWr, obsErr, rwRegs); end
    endtask

    task automatic test_random();
        logic        isRead;
        int          idx;
        logic [31:0] data;
        logic [3:0]  be;
        for (int n = 0; n < 80; n++) begin
            for (int i = 0; i < NRO; i++) begin
                roArr[i] = $urandom;
            end
            isRead = 1'($urandom_range(0, 1));
            idx    = $urandom_range(0, 31);
            data   = $urandom;
            be     = 4'($urandom_range(0, 15));
            modelAccess(isRead, idx, data, be);
            applyStimulus(isRead, idx, data, be, $urandom_range(0, 2));
            nCompared++; if (obsAcks !== 1 || obsAckAt !== 1 || obsRd !== isRead || obsWr !== !isRead) begin nMismatch++; $display("[TB] FAIL random[%0d].ack got acks=%0d at=%0d rd=%b wr=%b idx=%0d", n, obsAcks, obsAckAt, obsRd, obsWr, idx); end
            nCompared++; if (obsErr !== expErr) begin nMismatch++; $display("[TB] FAIL random[%0d].err got %b want %b idx=%0d", n, obsErr, expErr, idx); end
            if (isRead) begin
                nCompared++; if (obsData !== expData) begin nMismatch++; $display("[TB] FAIL random[%0d].data got %h want %h idx=%0d", n, obsData, expData, idx); end
            end
            nCompared++; if (obsStrb !== expStrb || obsClr !== expClr) begin nMismatch++; $display("[TB] FAIL random[%0d].pulses got strobe=%b clr=%h want %b %h", n, obsStrb, obsClr, expStrb, expClr); end
            nCompared++; if (obsRw !== packRw() || obsWo !== mdl[0]) begin nMismatch++; $display("[TB] FAIL random[%0d].regs got rw=%h wo=%h want %h %h", n, obsRw, obsWo, packRw(), mdl[0]); end
            nCompared++; if (obsStray !== 0) begin nMismatch++; $display("[TB] FAIL random[%0d].stray got %0d want 0", n, obsStray); end
        end
    endtask

    task automatic test_reset_mid();
        int extraAcks;
        @(posedge clk); #1;
        cs    = 1'b1;
        rnw   = 1'b0;
        addr  = 32'h0000_0004;
        wdata = 32'h0BAD_F00D;
        busBe = 4'hF;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        modelReset();
        nCompared++; if ({rdAck, wrAck, err} !== 3'b000) begin nMismatch++; $display("[TB] FAIL reset_mid.ack got %b want 000", {rdAck, wrAck, err}); end
        nCompared++; if (rdata !== 32'h0 || wrStrobe !== 9'h0 || rdClear !== 17'h0) begin nMismatch++; $display("[TB] FAIL reset_mid.outs got data=%h strobe=%b clr=%h want 0", rdata, wrStrobe, rdClear); end
        nCompared++; if (rwRegs !== packRw() || woRegs !== mdl[0]) begin nMismatch++; $display("[TB] FAIL reset_mid.regs got rw=%h wo=%h want %h %h", rwRegs, woRegs, packRw(), mdl[0]); end
        rst = 1'b0;
        cs  = 1'b0;
        extraAcks = 0;
        repeat (4) begin
            @(posedge clk); #1;
            if (rdAck || wrAck) extraAcks++;
        end
        nCompared++; if (extraAcks !== 0) begin nMismatch++; $display("[TB] FAIL reset_mid.late_ack got %0d want 0", extraAcks); end
    endtask

    // Run the scenarios in order and report.
    initial begin
        nCompared = 0;
        nMismatch = 0;
        corMask   = COR;
        rst   = 1'b1;
        cs    = 1'b0;
        rnw   = 1'b0;
        addr  = '0;
        wdata = '0;
        busBe = '0;
        for (int i = 0; i < NRO; i++) begin
            roArr[i] = $urandom;
        end
        modelReset();
        test_reset();
        test_be_write();
        test_hold_read();
        test_cor();
        test_unmapped();
        test_random();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatch);
        $finish;
    end

endmodule
